wakeup_msg_sequencer: RTL and testbench
=======================================

// Module: wakeup_msg_sequencer
// PURPOSE
//  Steps the 4-bit index of the registered character ROM (0..MSG_LEN-1 -> "Wake Up!\r") and streams each byte to the UART TX over valid/ready.
//  Sits between the alarm-compare logic and the UART transmitter.
//  Sends the message REPEAT times, with GAP_CYCLES idle cycles between repetitions.
//  Supports abort.
// PARAMETERS
//  MSG_LEN     9     characters per message (ROM indices 0..MSG_LEN-1), range 1..16
//  REPEAT      3     message repetitions per start, range >=1
//  GAP_CYCLES  1000  idle cycles between repetitions (tx_valid low), range >=1
//  REP_W       8     width of repetition counter
//  GAP_W       16    width of gap counter
// PORTS
//  clk        in   1  clock
//  rst        in   1  asynchronous reset, active-low
//  start      in   1  single-cycle request to send; sampled only in IDLE
//  abort      in   1  level; terminate sequence (rules below)
//  cnt_bcd    out  4  ROM index, registered
//  rom_data   in   8  ROM output; registered in ROM, valid 1 cycle after cnt_bcd
//  tx_data    out  8  byte to UART TX
//  tx_valid   out  1  byte valid; held until tx_ready
//  tx_ready   in   1  UART TX accepts byte when tx_valid & tx_ready
//  busy       out  1  state != IDLE
//  done       out  1  one-cycle pulse after full sequence completes
// BEHAVIOUR
//  Reset: state=IDLE; cnt_bcd=0; tx_data=8'h00; tx_valid=0; done=0; rep/gap counters=0.
//  States:
//  - IDLE: start & !abort -> FETCH; cnt_bcd<=0; rep<=0.
//  - FETCH: 1 cycle; ROM registers cnt_bcd -> LOAD.
//  - LOAD: tx_data<=rom_data; tx_valid<=1 -> SEND.
//  - SEND: hold tx_valid and tx_data stable until tx_valid&tx_ready; on handshake tx_valid<=0, then:
//    - cnt_bcd<MSG_LEN-1: cnt_bcd+1 -> FETCH
//    - last char, rep<REPEAT-1: rep+1, cnt_bcd<=0, gap<=0 -> GAP
//    - last char, rep==REPEAT-1 -> DONE
//  - GAP: gap counts up; at gap==GAP_CYCLES-1 -> FETCH (cnt_bcd already 0).
//  - DONE: done=1 for this cycle only -> IDLE. tx_data keeps last byte.
//  Timing, tx_ready high: start sampled at edge E0 -> tx_valid high after E2; 3 cycles per byte.
//  Full message ready-high: 3*MSG_LEN cycles from start edge to the last handshake edge.
//  Abort:
//  - FETCH/LOAD/GAP: -> IDLE next edge; tx_valid stays/forced 0; cnt_bcd<=0.
//  - SEND: the current byte completes its handshake (valid never dropped without ready), then -> IDLE.
//  - DONE: -> IDLE unchanged; done still pulses.
//  - Aborted sequences never pulse done.
//  start outside IDLE is ignored (no queueing). start & abort together in IDLE: stay IDLE.
//  cnt_bcd never exceeds MSG_LEN-1; counters saturate-free by construction (widths sized by parameters).
//  Reset asserted mid-sequence: immediate return to reset values; no partial byte is re-sent after release.
// STRUCTURE
//  Shared package: state encoding (IDLE, FETCH, LOAD, SEND, GAP, DONE, 3 bits), default MSG_LEN, ASCII constants for the message.
//  Sub-module: wakeup_gap_timer (load/enable/expire counter, GAP_W wide) used for the GAP state; the rest is a single FSM always block plus datapath registers.
//  Character ROM and UART TX are instantiated by the parent, not inside this block.
// TESTING
//  1. REPEAT=1, tx_ready=1, start pulse
//     -> tx_data sequence 57,61,6B,65,20,55,70,21,0D.
//     -> first tx_valid 2 cycles after start edge; one handshake every 3 cycles; done 1 cycle after last handshake; busy low after.
//  2. Backpressure: tx_ready low 5 cycles while byte 3 presented
//     -> tx_valid held, tx_data stable 8'h6B for all 5 cycles.
//     -> sequence resumes with 8'h65 and no byte lost or duplicated.
//  3. REPEAT=2, GAP_CYCLES=4
//     -> 18 bytes (message twice).
//     -> exactly 4 cycles of tx_valid=0 in GAP between 8'h0D and the next FETCH; single done pulse at end.
//  4. Abort:
//     - asserted during GAP -> IDLE next edge, no further bytes, no done.
//     - asserted in SEND with tx_ready low 3 cycles -> valid held until ready, then IDLE, no done.
//  5. start pulsed while busy -> ignored (byte count unchanged).
//     start+abort together in IDLE -> busy stays 0.
//  6. rst low mid-message (after byte 4)
//     -> all outputs at reset values asynchronously.
//     -> after release, a new start sends the message from 8'h57.

Source files
------------

// File: rtl/wakeup_msg_sequencer_pkg.sv
// Shared definitions for the wake-up message sequencer: FSM encoding,
// default message length and the ASCII bytes of "Wake Up!\r".
package wakeup_msg_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LOAD  = 3'd2,
      ST_SEND  = 3'd3,
      ST_GAP   = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   localparam int unsigned MSG_LEN_DEF = 9;

   localparam logic [7:0] CH_W   = 8'h57;
   localparam logic [7:0] CH_A   = 8'h61;
   localparam logic [7:0] CH_K   = 8'h6B;
   localparam logic [7:0] CH_E   = 8'h65;
   localparam logic [7:0] CH_SP  = 8'h20;
   localparam logic [7:0] CH_U   = 8'h55;
   localparam logic [7:0] CH_P   = 8'h70;
   localparam logic [7:0] CH_EXC = 8'h21;
   localparam logic [7:0] CH_CR  = 8'h0D;

   // Contents the parent's character ROM is expected to hold.
   function automatic logic [7:0] msg_char(input logic [3:0] idx);
      logic [7:0] ch;
      ch = 8'h00;
      case (idx)
         4'd0:    ch = CH_W;
         4'd1:    ch = CH_A;
         4'd2:    ch = CH_K;
         4'd3:    ch = CH_E;
         4'd4:    ch = CH_SP;
         4'd5:    ch = CH_U;
         4'd6:    ch = CH_P;
         4'd7:    ch = CH_EXC;
         4'd8:    ch = CH_CR;
         default: ch = 8'h00;
      endcase
      return ch;
   endfunction

endpackage

// File: rtl/wakeup_gap_timer.sv
// Idle-gap counter between message repetitions: cleared by load_i,
// counts while en_i, and flags the final gap cycle on expire_o.
module wakeup_gap_timer #(
   parameter int unsigned GAP_W      = 16,
   parameter int unsigned GAP_CYCLES = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic en_i,
   output logic expire_o
);

   logic [GAP_W-1:0] cnt_q;
   logic [GAP_W-1:0] cnt_d;

   assign expire_o = en_i && (cnt_q == GAP_W'(GAP_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = '0;
      end else if (en_i && !expire_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wakeup_msg_sequencer.sv
// Walks the character ROM index and streams each byte to the UART TX over
// valid/ready, repeating the message with idle gaps; supports abort.
module wakeup_msg_sequencer
   import wakeup_msg_sequencer_pkg::*;
#(
   parameter int unsigned MSG_LEN    = MSG_LEN_DEF,
   parameter int unsigned REPEAT     = 3,
   parameter int unsigned GAP_CYCLES = 1000,
   parameter int unsigned REP_W      = 8,
   parameter int unsigned GAP_W      = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   output logic [3:0] cnt_bcd,
   input  logic [7:0] rom_data,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       busy,
   output logic       done
);

   state_e           state_q;
   logic [3:0]       cnt_q;
   logic [REP_W-1:0] rep_q;
   logic [7:0]       tx_data_q;
   logic             tx_valid_q;
   logic             done_q;
   logic             abort_pend_q;

   logic hs;
   logic last_char;
   logic last_rep;
   logic stop_req;
   logic gap_load;
   logic gap_en;
   logic gap_expire;

   assign hs        = tx_valid_q && tx_ready;
   assign last_char = (cnt_q == 4'(MSG_LEN - 1));
   assign last_rep  = (rep_q == REP_W'(REPEAT - 1));
   // An abort seen while a byte is held must still end the sequence even if
   // the level drops before the receiver accepts that byte.
   assign stop_req  = abort || abort_pend_q;
   assign gap_load  = (state_q == ST_SEND) && hs && last_char && !last_rep && !stop_req;
   assign gap_en    = (state_q == ST_GAP);

   wakeup_gap_timer #(
      .GAP_W      (GAP_W),
      .GAP_CYCLES (GAP_CYCLES)
   ) u_gap_timer (
      .clk      (clk),
      .rst      (rst),
      .load_i   (gap_load),
      .en_i     (gap_en),
      .expire_o (gap_expire)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         rep_q        <= '0;
         tx_data_q    <= 8'h00;
         tx_valid_q   <= 1'b0;
         done_q       <= 1'b0;
         abort_pend_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               abort_pend_q <= 1'b0;
               if (start && !abort) begin
                  state_q <= ST_FETCH;
                  cnt_q   <= '0;
                  rep_q   <= '0;
               end
            end
            ST_FETCH: begin
               if (abort) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
               end else begin
                  state_q <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (abort) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
               end else begin
                  tx_data_q  <= rom_data;
                  tx_valid_q <= 1'b1;
                  state_q    <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (abort) begin
                  abort_pend_q <= 1'b1;
               end
               if (hs) begin
                  tx_valid_q <= 1'b0;
                  if (stop_req) begin
                     state_q      <= ST_IDLE;
                     cnt_q        <= '0;
                     abort_pend_q <= 1'b0;
                  end else if (!last_char) begin
                     cnt_q   <= cnt_q + 4'd1;
                     state_q <= ST_FETCH;
                  end else if (!last_rep) begin
                     rep_q   <= rep_q + 1'b1;
                     cnt_q   <= '0;
                     state_q <= ST_GAP;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end
               end
            end
            ST_GAP: begin
               if (abort) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
               end else if (gap_expire) begin
                  state_q <= ST_FETCH;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign cnt_bcd  = cnt_q;
   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign done     = done_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wakeup_msg_sequencer.sv
// Scoreboard bench for wakeup_msg_sequencer with an external registered ROM
// model; expected bytes, done pulses and handshake timing come from the message rules.
module tb_wakeup_msg_sequencer;

   localparam int MSG_LEN = 9;
   localparam int REPEAT  = 2;
   localparam int GAP     = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] cnt_bcd;
   logic [7:0] rom_data;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       done;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int hs_total = 0;
   int exp_done = 0;
   logic [7:0] exp_q[$];
   int hs_edges[$];
   int done_edges[$];

   logic rnd_mode  = 1'b0;
   logic rdy_force = 1'b1;
   logic rnd_rdy   = 1'b1;
   int   rdy_pct   = 100;

   logic [7:0] exp_msg [MSG_LEN] = '{8'h57, 8'h61, 8'h6B, 8'h65, 8'h20, 8'h55, 8'h70, 8'h21, 8'h0D};
   logic [7:0] rom [16];

   assign tx_ready = rnd_mode ? rnd_rdy : rdy_force;

   wakeup_msg_sequencer #(
      .MSG_LEN    (MSG_LEN),
      .REPEAT     (REPEAT),
      .GAP_CYCLES (GAP),
      .REP_W      (8),
      .GAP_W      (16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .cnt_bcd  (cnt_bcd),
      .rom_data (rom_data),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .busy     (busy),
      .done     (done)
   );

   initial begin
      string s;
      s = "Wake Up!";
      for (int i = 0; i < 16; i++) rom[i] = 8'h00;
      for (int i = 0; i < s.len(); i++) rom[i] = s[i];
      rom[8] = 8'h0D;
   end

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) rom_data <= rom[cnt_bcd];
   always @(posedge clk) begin
      #1;
      rnd_rdy = ($urandom_range(99) < rdy_pct);
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on every handshake and done pulse.
   logic       prev_hold = 1'b0;
   logic [7:0] prev_data = 8'h00;
   always @(negedge clk) begin
      if (!rst) begin
         prev_hold = 1'b0;
      end else begin
         chk("cnt_range", int'(cnt_bcd <= 4'(MSG_LEN - 1)), 1);
         if (prev_hold) begin
            chk("hold_valid", int'(tx_valid), 1);
            chk("hold_data", int'(tx_data), int'(prev_data));
         end
         prev_hold = tx_valid && !tx_ready;
         prev_data = tx_data;
         if (tx_valid && tx_ready) begin
            hs_total++;
            hs_edges.push_back(cyc + 1);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_byte: got %0h want none (cycle %0d)", tx_data, cyc);
            end else begin
               chk("sb_byte", int'(tx_data), int'(exp_q.pop_front()));
            end
         end
         if (done) begin
            chk("sb_done_expected", int'(exp_done > 0), 1);
            if (exp_done > 0) exp_done--;
            done_edges.push_back(cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(output int e0);
      start = 1'b1;
      tick();
      e0 = cyc;
      start = 1'b0;
   endtask

   task automatic exp_run(input int nbytes, input bit with_done);
      for (int j = 0; j < nbytes; j++) exp_q.push_back(exp_msg[j % MSG_LEN]);
      if (with_done) exp_done++;
   endtask

   task automatic wait_hs(input int target, input int budget, input string name);
      int n = 0;
      while (hs_total < target && n < budget) begin
         tick();
         n++;
      end
      chk(name, int'(hs_total >= target), 1);
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while ((busy || exp_done != 0) && n < budget) begin
         tick();
         n++;
      end
      chk(name, int'(!busy && exp_done == 0), 1);
   endtask

   task automatic wait_valid(input int budget, input string name);
      int n = 0;
      @(negedge clk);
      while (!tx_valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, int'(tx_valid), 1);
   endtask

   initial begin
      int e0, dummy, base;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cnt", int'(cnt_bcd), 0);
      chk("rst_data", int'(tx_data), 0);
      chk("rst_valid", int'(tx_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      rst = 1'b1;
      tick();
      tick();

      // Full two-repetition run with ready high: latency, cadence, gap and done.
      base = hs_total;
      hs_edges.delete();
      done_edges.delete();
      exp_run(MSG_LEN * REPEAT, 1'b1);
      pulse_start(e0);
      @(negedge clk);
      chk("t1_busy", int'(busy), 1);
      chk("t1_valid_e0", int'(tx_valid), 0);
      @(negedge clk);
      chk("t1_valid_e1", int'(tx_valid), 0);
      @(negedge clk);
      chk("t1_valid_e2", int'(tx_valid), 1);
      wait_idle(300, "t1_idle");
      chk("t1_hs_count", hs_total - base, MSG_LEN * REPEAT);
      for (int j = 0; j < hs_edges.size(); j++)
         chk("t1_hs_edge", hs_edges[j], e0 + 3 * (j + 1) + (j / MSG_LEN) * GAP);
      chk("t1_done_count", done_edges.size(), 1);
      if (done_edges.size() > 0)
         chk("t1_done_edge", done_edges[0], e0 + 3 * MSG_LEN * REPEAT + GAP);

      // Backpressure on the third byte.
      base = hs_total;
      exp_run(MSG_LEN * REPEAT, 1'b1);
      pulse_start(dummy);
      wait_hs(base + 2, 50, "t2_reach_b2");
      rdy_force = 1'b0;
      wait_valid(10, "t2_valid_seen");
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk("t2_held_valid", int'(tx_valid), 1);
         chk("t2_held_data", int'(tx_data), int'(exp_msg[2]));
      end
      tick();
      rdy_force = 1'b1;
      wait_idle(300, "t2_idle");
      chk("t2_hs_count", hs_total - base, MSG_LEN * REPEAT);

      // Abort while in the inter-repetition gap.
      base = hs_total;
      exp_run(MSG_LEN, 1'b0);
      pulse_start(dummy);
      wait_hs(base + MSG_LEN, 100, "t4a_reach_gap");
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t4a_busy", int'(busy), 0);
      repeat (GAP + 8) tick();
      chk("t4a_hs_count", hs_total - base, MSG_LEN);
      chk("t4a_sb_empty", exp_q.size(), 0);
      chk("t4a_valid", int'(tx_valid), 0);

      // Abort while a byte is held by backpressure.
      rdy_force = 1'b0;
      base = hs_total;
      exp_run(1, 1'b0);
      pulse_start(dummy);
      wait_valid(10, "t4b_valid_seen");
      tick();
      abort = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t4b_held_valid", int'(tx_valid), 1);
         chk("t4b_held_data", int'(tx_data), int'(exp_msg[0]));
      end
      tick();
      rdy_force = 1'b1;
      tick();
      abort = 1'b0;
      tick();
      chk("t4b_busy", int'(busy), 0);
      repeat (10) tick();
      chk("t4b_hs_count", hs_total - base, 1);
      chk("t4b_sb_empty", exp_q.size(), 0);

      // start while busy is ignored; start with abort in IDLE does nothing.
      base = hs_total;
      exp_run(MSG_LEN * REPEAT, 1'b1);
      pulse_start(dummy);
      wait_hs(base + 3, 50, "t5_reach_b3");
      pulse_start(dummy);
      wait_hs(base + 12, 100, "t5_reach_b12");
      pulse_start(dummy);
      wait_idle(300, "t5_idle");
      chk("t5_hs_count", hs_total - base, MSG_LEN * REPEAT);
      base = hs_total;
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("t5_sa_busy0", int'(busy), 0);
      repeat (5) tick();
      chk("t5_sa_busy1", int'(busy), 0);
      chk("t5_sa_hs", hs_total - base, 0);

      // Asynchronous reset in the middle of a message.
      base = hs_total;
      exp_run(MSG_LEN * REPEAT, 1'b1);
      pulse_start(dummy);
      wait_hs(base + 4, 50, "t6_reach_b4");
      #2;
      rst = 1'b0;
      #1;
      chk("t6_cnt", int'(cnt_bcd), 0);
      chk("t6_data", int'(tx_data), 0);
      chk("t6_valid", int'(tx_valid), 0);
      chk("t6_busy", int'(busy), 0);
      chk("t6_done", int'(done), 0);
      exp_q.delete();
      exp_done = 0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      base = hs_total;
      exp_run(MSG_LEN * REPEAT, 1'b1);
      pulse_start(dummy);
      wait_idle(300, "t6_idle");
      chk("t6_hs_count", hs_total - base, MSG_LEN * REPEAT);

      // Randomized ready with stray start pulses mid-run.
      rnd_mode = 1'b1;
      for (int r = 0; r < 5; r++) begin
         rdy_pct = $urandom_range(100, 30);
         base = hs_total;
         exp_run(MSG_LEN * REPEAT, 1'b1);
         pulse_start(dummy);
         repeat ($urandom_range(40, 5)) tick();
         pulse_start(dummy);
         wait_idle(3000, "rnd_idle");
         chk("rnd_hs_count", hs_total - base, MSG_LEN * REPEAT);
      end
      rnd_mode = 1'b0;
      tick();
      chk("end_sb_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule
